// File: rtl/pcpu_pkg.sv
// rtl/pcpu_pkg.sv - shared width defaults, arbiter FSM state and read-owner encodings
package pcpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_H    = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - RUN-mode winner between fetch and data ports
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic pick_i,
    output logic pick_d
);

    // On conflict the port not served last wins; last_d held low gives plain d>i priority.
    assign pick_d = d_req & (~i_req | ~last_d);
    assign pick_i = i_req & ~pick_d;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch, data and host loader (MEM_ARBITER_RR_EN: i/d round-robin)
module mem_arbiter
    import pcpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              cpu_stall
);

    state_t            state;
    state_t            state_nx;
    owner_t            owner;
    owner_t            owner_nx;
    logic              last_d;
    logic              pick_i;
    logic              pick_d;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] h_rdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:  if (h_req)  state_nx = ST_HOST;
            ST_HOST: if (!h_req) state_nx = ST_RUN;
        endcase
    end

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_d (last_d),
        .pick_i (pick_i),
        .pick_d (pick_d)
    );

    // The cycle that raises h_req is still served as RUN; HOST takes effect next edge.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        h_gnt    = 1'b0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        owner_nx = OWN_NONE;
        if (state == ST_HOST) begin
            if (h_req) begin
                h_gnt   = 1'b1;
                m_en    = 1'b1;
                m_we    = h_we;
                m_addr  = h_addr;
                m_wdata = h_wdata;
                if (!h_we) owner_nx = OWN_H;
            end
        end else if (pick_d) begin
            d_gnt   = 1'b1;
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            if (!d_we) owner_nx = OWN_D;
        end else if (pick_i) begin
            i_gnt    = 1'b1;
            m_en     = 1'b1;
            m_addr   = i_addr;
            owner_nx = OWN_I;
        end
    end

    assign cpu_stall = (i_req & ~i_gnt) | (d_req & ~d_gnt) | (state == ST_HOST);

`ifdef MEM_ARBITER_RR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (i_gnt | d_gnt) begin
            last_d <= d_gnt;
        end
    end
`else
    assign last_d = 1'b0;
`endif

    // Owner tags the port whose read returns this cycle; reset drops any read in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner     <= OWN_NONE;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            owner <= owner_nx;
            if (owner == OWN_I) i_rdata_q <= m_rdata;
            if (owner == OWN_D) d_rdata_q <= m_rdata;
            if (owner == OWN_H) h_rdata_q <= m_rdata;
        end
    end

    assign i_rvalid = (owner == OWN_I);
    assign d_rvalid = (owner == OWN_D);
    assign h_rvalid = (owner == OWN_H);
    assign i_rdata  = i_rvalid ? m_rdata : i_rdata_q;
    assign d_rdata  = d_rvalid ? m_rdata : d_rdata_q;
    assign h_rdata  = h_rvalid ? m_rdata : h_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a synchronous memory model
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          h_req, h_we, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          cpu_stall;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .cpu_stall(cpu_stall)
    );

    // Unwritten locations read back a fixed pattern; location 5 holds 0x4A24.
    logic [DW-1:0] mem [256];
    logic          wr_valid [256];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h05) ? 16'h4A24 : {8'hA5, a};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) wr_valid[k] <= 1'b0;
        end else if (m_en) begin
            if (m_we) begin
                mem[m_addr]      <= m_wdata;
                wr_valid[m_addr] <= 1'b1;
            end else begin
                m_rdata <= wr_valid[m_addr] ? mem[m_addr] : init_val(m_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        settle;
        chk("rst_gnts", {29'b0, i_gnt, d_gnt, h_gnt}, 32'h0);
        chk("rst_rvalids", {29'b0, i_rvalid, d_rvalid, h_rvalid}, 32'h0);
        chk("rst_mem_cmd", {30'b0, m_en, m_we}, 32'h0);
        chk("rst_rdata", {i_rdata, d_rdata ^ h_rdata}, 32'h0);
        chk("rst_stall", cpu_stall, 0);
        tick;
        reset = 1'b0;

        // single fetch
        i_req = 1; i_addr = 8'h05;
        settle;
        chk("fetch_gnt", {i_gnt, d_gnt, h_gnt}, 3'b100);
        chk("fetch_cmd", {m_en, m_we, m_addr}, {2'b10, 8'h05});
        chk("fetch_stall", cpu_stall, 0);
        tick;
        i_req = 0;
        settle;
        chk("fetch_rvalid", {i_rvalid, d_rvalid, h_rvalid}, 3'b100);
        chk("fetch_rdata", i_rdata, 16'h4A24);
        tick;
        settle;
        chk("fetch_rvalid_low", i_rvalid, 0);
        chk("fetch_rdata_held", i_rdata, 16'h4A24);

        // i and d together
        tick;
        i_req = 1; i_addr = 8'h40;
        d_req = 1; d_we = 0; d_addr = 8'h10;
        settle;
        chk("conf_c1_gnt", {i_gnt, d_gnt}, 2'b01);
        chk("conf_c1_stall", cpu_stall, 1);
        chk("conf_c1_addr", m_addr, 8'h10);
        tick;
        d_req = 0;
        settle;
        chk("conf_c2_gnt", {i_gnt, d_gnt}, 2'b10);
        chk("conf_c2_stall", cpu_stall, 0);
        chk("conf_c2_drvalid", {d_rvalid, d_rdata}, {1'b1, 16'hA510});
        tick;
        i_req = 0;
        settle;
        chk("conf_c3_irvalid", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 16'hA540});
        chk("conf_c3_drdata_held", d_rdata, 16'hA510);

        // both held four cycles; last served is i at this point
        tick;
        i_req = 1; i_addr = 8'h05;
        d_req = 1; d_addr = 8'h10;
        for (int c = 0; c < 4; c++) begin
            settle;
`ifdef MEM_ARBITER_RR_EN
            chk($sformatf("hold_gnt%0d", c), {i_gnt, d_gnt}, (c % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk($sformatf("hold_gnt%0d", c), {i_gnt, d_gnt}, 2'b01);
`endif
            if (c > 0) chk($sformatf("hold_rvalid%0d", c), i_rvalid | d_rvalid, 1);
            tick;
        end
        i_req = 0; d_req = 0;
        tick;

        // host write while CPU requests
        i_req = 1; i_addr = 8'h05;
        h_req = 1; h_we = 1; h_addr = 8'h20; h_wdata = 16'h1234;
        settle;
        chk("host_a_gnt", {i_gnt, d_gnt, h_gnt}, 3'b100);
        chk("host_a_stall", cpu_stall, 0);
        tick;
        settle;
        chk("host_b_gnt", {i_gnt, d_gnt, h_gnt}, 3'b001);
        chk("host_b_stall", cpu_stall, 1);
        chk("host_b_cmd", {m_en, m_we, m_addr, m_wdata}, {2'b11, 8'h20, 16'h1234});
        chk("host_b_irvalid", {i_rvalid, i_rdata}, {1'b1, 16'h4A24});
        tick;
        h_req = 0;
        settle;
        chk("host_c_gnt", {i_gnt, h_gnt, h_rvalid}, 3'b000);
        chk("host_c_stall", cpu_stall, 1);
        tick;
        i_addr = 8'h20;
        settle;
        chk("host_d_gnt", {i_gnt, cpu_stall}, 2'b10);
        tick;
        i_req = 0;
        settle;
        chk("host_e_rdata", {i_rvalid, i_rdata}, {1'b1, 16'h1234});
        tick;

        // i, h, d reads across RUN->HOST->RUN
        i_req = 1; i_addr = 8'h05;
        h_req = 1; h_we = 0; h_addr = 8'h30;
        settle;
        chk("seq1_gnt", {i_gnt, d_gnt, h_gnt}, 3'b100);
        tick;
        i_req = 0;
        d_req = 1; d_we = 0; d_addr = 8'h10;
        settle;
        chk("seq2_gnt", {i_gnt, d_gnt, h_gnt}, 3'b001);
        chk("seq2_rv", {i_rvalid, d_rvalid, h_rvalid, i_rdata}, {3'b100, 16'h4A24});
        tick;
        h_req = 0;
        settle;
        chk("seq3_gnt", {d_gnt, h_gnt}, 2'b00);
        chk("seq3_rv", {i_rvalid, d_rvalid, h_rvalid, h_rdata}, {3'b001, 16'hA530});
        tick;
        settle;
        chk("seq4_gnt", {i_gnt, d_gnt, h_gnt, m_addr}, {3'b010, 8'h10});
        tick;
        d_req = 0;
        settle;
        chk("seq5_rv", {i_rvalid, d_rvalid, h_rvalid, d_rdata}, {3'b010, 16'hA510});
        chk("seq5_hheld", h_rdata, 16'hA530);
        tick;

        // reset while a d read is in flight
        d_req = 1; d_we = 0; d_addr = 8'h05;
        settle;
        chk("rstfl_gnt", d_gnt, 1);
        tick;
        d_req = 0;
        reset = 1'b1;
        settle;
        chk("rstfl_rvalid", {i_rvalid, d_rvalid, h_rvalid}, 3'b000);
        chk("rstfl_rdata", {i_rdata, d_rdata}, 32'h0);
        chk("rstfl_hrdata", h_rdata, 16'h0);
        chk("rstfl_cmd", {m_en, m_we, cpu_stall}, 3'b000);
        tick;
        reset = 1'b0;
        settle;
        chk("rstfl_post_rvalid", {i_rvalid, d_rvalid, h_rvalid}, 3'b000);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, address width of every port.
REQ-002 Parameter DATA_W, default 16, data width of every port.
REQ-003 clock  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 i_req/i_addr  in  1/ADDR_W  CPU fetch request, read-only, held until granted.
REQ-006 i_gnt/i_rvalid/i_rdata  out  1/1/DATA_W  fetch accepted; read data valid one cycle after grant.
REQ-007 d_req/d_we/d_addr/d_wdata  in  1/1/ADDR_W/DATA_W  CPU data request, held until granted.
REQ-008 d_gnt/d_rvalid/d_rdata  out  1/1/DATA_W  data accepted; read data valid one cycle after a granted read.
REQ-009 h_req/h_we/h_addr/h_wdata  in  1/1/ADDR_W/DATA_W  host loader request.
REQ-010 h_gnt/h_rvalid/h_rdata  out  1/1/DATA_W  host accepted; read data return.
REQ-011 m_en/m_we/m_addr/m_wdata  out  1/1/ADDR_W/DATA_W  single-port synchronous memory command.
REQ-012 m_rdata  in  DATA_W  memory read data, valid the cycle after m_en with m_we=0.
REQ-013 cpu_stall  out  1  high when the CPU has any ungranted request or the FSM is in HOST; drives the CPU enable low.

Function
REQ-014 At most one memory command per cycle; grants are combinational in the cycle of acceptance (gnt=req&selected).
REQ-015 FSM states RUN and HOST; RUN->HOST on the clock edge where h_req=1; HOST->RUN on the first edge where h_req=0.
REQ-016 In RUN: i and d arbitrated, h_gnt=0; d wins over i (fixed priority) unless the RR feature is compiled in.
REQ-017 In HOST: h_gnt=h_req, i_gnt=d_gnt=0.
REQ-018 Requests arriving on the same cycle as the RUN->HOST transition are still arbitrated as RUN in that cycle.
REQ-019 A 2-bit owner register records the port of each granted read; the following cycle exactly one of i/d/h_rvalid is high and its rdata equals m_rdata.
REQ-020 Writes produce no rvalid; rdata outputs of non-owners are held at their last value.
REQ-021 Back-to-back reads to the same or different ports are sustained at one per cycle with no bubble.
REQ-022 Addresses are passed through unmodified; no wrap or range check.

Reset
REQ-023 On reset: FSM=RUN, owner=none, last-served=i, all gnt/rvalid/m_en/m_we=0, all rdata=0, cpu_stall=0.
REQ-024 Reset asserted while a read is in flight discards the return; no rvalid after reset release.

Configuration
REQ-025 Macro MEM_ARBITER_RR_EN defined: i and d round-robin in RUN; the port not served last wins on conflict; last-served updates on each CPU grant.
REQ-026 Macro undefined: fixed priority d>i, no last-served register synthesized.

Structure
REQ-027 Shared package pcpu_pkg holds ADDR_W/DATA_W defaults, the FSM state encoding (RUN, HOST) and owner encoding (NONE, I, D, H).
REQ-028 One combinational sub-module, mem_arb_pick, computes the RUN-mode winner from i_req, d_req and last-served.

Verification
REQ-029 i_req alone, i_addr=0x05, memory[5]=0x4A24 -> i_gnt same cycle, i_rvalid next cycle with i_rdata=0x4A24.
REQ-030 i_req and d_req together (d read 0x10) without RR -> d_gnt cycle 1, i_gnt cycle 2, cpu_stall high only in cycle 1.
REQ-031 With MEM_ARBITER_RR_EN, i and d held high 4 cycles -> grants alternate d,i,d,i after reset (last-served=i).
REQ-032 h_req with h_we=1, h_addr=0x20, h_wdata=0x1234 while CPU requests -> HOST next cycle, CPU gnts 0, cpu_stall=1; later CPU read of 0x20 returns 0x1234.
REQ-033 Reset asserted the cycle after a d read grant -> no d_rvalid, all outputs at reset values.
REQ-034 Alternating reads i,d,h across a RUN->HOST->RUN sequence -> each rvalid on the correct port, one cycle after its grant.
